// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter: default widths and grant FSM states.
// Imported by vram_arbiter and vram_wr_fifo.
package vram_pkg;

  localparam int ADDR_W_DEF     = 15;
  localparam int DATA_W_DEF     = 8;
  localparam int WF_DEPTH_DEF   = 4;
  localparam int STARVE_MAX_DEF = 1023;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } gnt_state_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous write FIFO holding {addr, data} words for the VRAM arbiter.
// Ports: clk, rst_n, push/din, pop/dout (head), empty, count.
module vram_wr_fifo
  import vram_pkg::*;
#(
  parameter int W     = ADDR_W_DEF + DATA_W_DEF,
  parameter int DEPTH = WF_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (count != CW'(DEPTH));
  assign dout    = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port pixel RAM arbiter: display reads win, queued writes drain in
// free cycles. Ports: disp_* read side, wr_* writer side, mem_* RAM side,
// vblank gate, wr_starved flag. Option macro: VRAM_VBLANK_WR_EN.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int WF_DEPTH   = WF_DEPTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              vblank,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_starved,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(WF_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  gnt_state_t          state;
  gnt_state_t          state_nxt;
  logic [CW-1:0]       fifo_cnt;
  logic                fifo_empty;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_data;
  logic                push;
  logic                pop;
  logic                wr_ok;
  logic                rd_p1;
  logic                starve_hit;
  logic [SW-1:0]       starve_cnt;

`ifdef VRAM_VBLANK_WR_EN
  assign wr_ok = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign wr_ok = 1'b1;
`endif

  assign wr_ready = (fifo_cnt != CW'(WF_DEPTH));
  assign push     = wr_valid & wr_ready;
  assign pop      = (state_nxt == WR);

  vram_wr_fifo #(
    .W     (ADDR_W + DATA_W),
    .DEPTH (WF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({wr_addr, wr_data}),
    .pop   (pop),
    .dout  ({head_addr, head_data}),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_comb begin
    state_nxt = IDLE;
    unique case (1'b1)
      disp_req:                             state_nxt = RD;
      (!disp_req && !fifo_empty && wr_ok):  state_nxt = WR;
      default:                              ;
    endcase
  end

  // Fires in the denied cycle that brings the counter to STARVE_MAX.
  assign starve_hit = !fifo_empty && !pop && wr_ok &&
                      (starve_cnt == SW'(STARVE_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rd_p1      <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
      starve_cnt <= '0;
      wr_starved <= 1'b0;
    end else begin
      state  <= state_nxt;
      mem_en <= (state_nxt != IDLE);
      mem_we <= (state_nxt == WR);
      unique case (state_nxt)
        RD: mem_addr <= disp_addr;
        WR: begin
          mem_addr  <= head_addr;
          mem_wdata <= head_data;
        end
        default: ;
      endcase
      // RAM returns data the cycle after the read; register it once more.
      rd_p1      <= (state == RD);
      disp_valid <= rd_p1;
      if (rd_p1) disp_data <= mem_rdata;
      if (fifo_empty || pop) begin
        starve_cnt <= '0;
      end else if (wr_ok && starve_cnt != SW'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
      if (starve_hit) wr_starved <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed scenarios plus random traffic
// checked cycle by cycle against a queue-based reference model.
module tb_vram_arbiter;

  localparam int DEPTH = 4;
  localparam int SMAX  = 15;

  typedef struct packed {
    logic [14:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        disp_req;
  logic [14:0] disp_addr;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        vblank;
  logic        wr_valid;
  logic        wr_ready;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_starved;
  logic        mem_en;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] ram     [0:32767];
  logic [7:0] ref_mem [0:32767];

  wr_t        wq[$];
  bit         h0_v, h1_v;
  logic [7:0] h0_d, h1_d;
  bit         pw_v;
  wr_t        pw;
  bit         exp_dv, exp_en, exp_we;
  logic [7:0] exp_dd, exp_wdata;
  logic [14:0] exp_addr;
  int         scnt;
  bit         starved;

  vram_arbiter #(
    .ADDR_W     (15),
    .DATA_W     (8),
    .WF_DEPTH   (DEPTH),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .vblank     (vblank),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_starved (wr_starved),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM macro.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_clear();
    wq.delete();
    h0_v = 0; h1_v = 0; pw_v = 0;
    exp_dv = 0; exp_en = 0; exp_we = 0;
    scnt = 0; starved = 0;
  endtask

  task automatic rst_chk();
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_disp_data", disp_data, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_wr_starved", wr_starved, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    rst_chk();
    ref_clear();
    disp_req = 0;
    wr_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  // One clock: predict from the sampled inputs, advance, compare.
  task automatic step();
    bit ok, rd, wr, push;
    ok = 1;
`ifdef VRAM_VBLANK_WR_EN
    ok = vblank;
`endif
    rd   = disp_req;
    wr   = !rd && (wq.size() > 0) && ok;
    push = wr_valid && (wq.size() < DEPTH);
    if (wq.size() == 0 || wr) scnt = 0;
    else if (ok && scnt < SMAX) begin
      scnt++;
      if (scnt == SMAX) starved = 1;
    end
    if (pw_v) ref_mem[pw.a] = pw.d;
    pw_v   = 0;
    exp_dv = h1_v;
    exp_dd = h1_d;
    h1_v   = h0_v;
    h1_d   = h0_d;
    h0_v   = rd;
    h0_d   = rd ? ref_mem[disp_addr] : 8'h00;
    exp_en = rd || wr;
    exp_we = wr;
    if (rd) exp_addr = disp_addr;
    if (wr) begin
      pw        = wq.pop_front();
      pw_v      = 1;
      exp_addr  = pw.a;
      exp_wdata = pw.d;
    end
    if (push) wq.push_back({wr_addr, wr_data});
    @(posedge clk);
    #1;
    cyc++;
    chk("disp_valid", disp_valid, exp_dv);
    if (exp_dv) chk("disp_data", disp_data, exp_dd);
    chk("mem_en", mem_en, exp_en);
    chk("mem_we", mem_we, exp_we);
    if (exp_en) chk("mem_addr", mem_addr, exp_addr);
    if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
    chk("wr_ready", wr_ready, 32'(wq.size() < DEPTH));
    chk("wr_starved", wr_starved, starved);
  endtask

  initial begin
    int vc[$];
    logic [7:0] vd[$];
    int wc[$];
    logic [14:0] wa[$];
    logic [7:0] wd[$];
    int nwe;
    int rate;

    rst_n = 1'b1;
    disp_req = 0; disp_addr = '0;
    vblank = 1; wr_valid = 0; wr_addr = '0; wr_data = '0;
    for (int a = 0; a < 32768; a++) begin
      ram[a]     = 8'(a) ^ 8'h5A;
      ref_mem[a] = 8'(a) ^ 8'h5A;
    end
    for (int a = 0; a < 3; a++) begin
      ram[a]     = 8'hA0 + 8'(a);
      ref_mem[a] = 8'hA0 + 8'(a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    rst_chk();
    ref_clear();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc = 0;

    // Reads only.
    nwe = 0;
    while (cyc < 20) begin
      disp_req  = (cyc >= 10 && cyc <= 12);
      disp_addr = disp_req ? 15'(cyc - 10) : 15'h0;
      step();
      if (disp_valid) begin
        vc.push_back(cyc);
        vd.push_back(disp_data);
      end
      if (mem_we) nwe++;
    end
    chk("t1_nvalid", vc.size(), 3);
    for (int i = 0; i < vc.size() && i < 3; i++) begin
      chk("t1_cycle", vc[i], 13 + i);
      chk("t1_data", vd[i], 8'hA0 + i);
    end
    chk("t1_no_we", nwe, 0);

    // Idle writes and readback.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      wr_valid = (k < 2);
      wr_addr  = (k == 0) ? 15'h100 : 15'h101;
      wr_data  = (k == 0) ? 8'h1C : 8'hE3;
      step();
      if (mem_we) begin
        wc.push_back(cyc);
        wa.push_back(mem_addr);
        wd.push_back(mem_wdata);
      end
    end
    wr_valid = 0;
    chk("t2_nwe", wc.size(), 2);
    if (wc.size() == 2) begin
      chk("t2_cyc0", wc[0], 2);
      chk("t2_cyc1", wc[1], 3);
      chk("t2_addr0", wa[0], 15'h100);
      chk("t2_addr1", wa[1], 15'h101);
      chk("t2_data0", wd[0], 8'h1C);
      chk("t2_data1", wd[1], 8'hE3);
    end
    vd.delete();
    for (int k = 0; k < 6; k++) begin
      disp_req  = (k < 2);
      disp_addr = (k == 0) ? 15'h100 : 15'h101;
      step();
      if (disp_valid) vd.push_back(disp_data);
    end
    disp_req = 0;
    chk("t2_nread", vd.size(), 2);
    if (vd.size() == 2) begin
      chk("t2_rd0", vd[0], 8'h1C);
      chk("t2_rd1", vd[1], 8'hE3);
    end

    // Contention: display holds the RAM for 20 cycles.
    do_reset();
    nwe = 0;
    for (int k = 0; k < 20; k++) begin
      disp_req  = 1;
      disp_addr = 15'(k);
      wr_valid  = (k < 4);
      wr_addr   = 15'h200 + 15'(k);
      wr_data   = 8'($urandom);
      step();
      if (k == 3) chk("t3_ready_full", wr_ready, 0);
      if (mem_we) nwe++;
    end
    wr_valid = 0;
    disp_req = 0;
    chk("t3_no_we", nwe, 0);
    nwe = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (mem_we) nwe++;
    end
    chk("t3_drain4", nwe, 4);
    step();
    chk("t3_ready_after", wr_ready, 1);

    // Starvation.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      disp_req = 1;
      disp_addr = 15'(k);
      wr_valid = (k == 0);
      wr_addr  = 15'h300;
      wr_data  = 8'h77;
      step();
      if (k == 14) chk("t4_not_yet", wr_starved, 0);
      if (k == 15) chk("t4_starved", wr_starved, 1);
    end
    disp_req = 0;
    wr_valid = 0;
    nwe = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (mem_we) nwe++;
    end
    chk("t4_drained", nwe, 1);
    chk("t4_sticky", wr_starved, 1);

    // Reset with queued writes and reads in flight.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      disp_req = 1;
      disp_addr = 15'(k);
      wr_valid = 1;
      wr_addr  = 15'h400 + 15'(k);
      wr_data  = 8'($urandom);
      step();
    end
    wr_valid = 0;
    do_reset();
    nwe = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (mem_we || disp_valid) nwe++;
    end
    chk("t5_quiet", nwe, 0);
    chk("t5_ready", wr_ready, 1);

    // vblank gating.
    do_reset();
    vblank = 0;
    nwe = 0;
    for (int k = 0; k < 5; k++) begin
      wr_valid = (k == 0);
      wr_addr  = 15'h500;
      wr_data  = 8'h3C;
      step();
      if (mem_we) nwe++;
    end
    wr_valid = 0;
`ifdef VRAM_VBLANK_WR_EN
    chk("t6_held", nwe, 0);
    vblank = 1;
    step();
    chk("t6_granted", mem_we, 1);
`else
    chk("t6_granted", nwe, 1);
`endif
    vblank = 1;

    // Random traffic.
    do_reset();
    rate = 50;
    for (int i = 0; i < 2000; i++) begin
      if (i % 250 == 0) rate = $urandom_range(10, 95);
      if (i == 1000) do_reset();
      disp_req  = ($urandom_range(0, 99) < rate);
      disp_addr = 15'($urandom_range(0, 63));
      wr_valid  = $urandom_range(0, 1) == 1;
      wr_addr   = 15'($urandom_range(0, 63));
      wr_data   = 8'($urandom);
      if ($urandom_range(0, 19) == 0) vblank = ~vblank;
      step();
    end
    disp_req = 0;
    wr_valid = 0;
    vblank   = 1;
    for (int k = 0; k < 20; k++) step();
    chk("final_ready", wr_ready, 1);
    for (int a = 0; a < 64; a++) chk("final_ram", ram[a], ref_mem[a]);
    chk("final_ram_100", ram[15'h100], 8'h1C);
    chk("final_ram_101", ram[15'h101], 8'hE3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
